// File: rtl/rr_mux_arb.sv
// Registered N-to-1 selector with round-robin / fixed-priority arbitration
// and a valid/ready output stage for sharing one bus port among requesters.
module rr_mux_arb #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       req_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic                      mode_i,
  input  logic                      ready_i,
  output logic [CHANNELS-1:0]       grant_o,
  output logic [WIDTH-1:0]          data_o,
  output logic [SELW-1:0]           sel_o,
  output logic                      valid_o
);

  logic [SELW-1:0]  last_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;

  logic [SELW-1:0]  winner;
  logic [SELW-1:0]  idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] win_data;

  // Winner search: rotating start after last_q, or plain lowest index.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    if (mode_i) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!found && req_i[SELW'(i)]) begin
          winner = SELW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
        idx = SELW'((32'(last_q) + i) % CHANNELS);
        if (!found && req_i[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (SELW'(k) == winner) win_data = data_i[k*WIDTH +: WIDTH];
    end
  end

  assign load = (!valid_q || ready_i) && (|req_i) && !rst_i;

  always_comb begin
    grant_o = '0;
    if (load) grant_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(CHANNELS - 1);
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= win_data;
      sel_q   <= winner;
      last_q  <= winner;
    end else if (ready_i && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: directed scenarios plus randomized
// traffic, all compared against an arithmetic reference model.
module tb_rr_mux_arb;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic           mode;
  logic           ready;
  logic [N-1:0]   grant;
  logic [W-1:0]   dout;
  logic [1:0]     sel;
  logic           valid;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit             m_valid = 1'b0;
  logic [W-1:0]   m_data  = '0;
  int             m_sel   = 0;
  int             m_last  = N - 1;

  rr_mux_arb #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .mode_i(mode),
    .ready_i(ready), .grant_o(grant), .data_o(dout), .sel_o(sel), .valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Round-robin winner = requester at smallest circular distance past m_last.
  function automatic int model_winner();
    int best  = -1;
    int bestd = N;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        if (mode) begin
          if (best < 0) best = k;
        end else begin
          int d = (k - m_last - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = k;
          end
        end
      end
    end
    return best;
  endfunction

  function automatic bit model_load();
    return (!m_valid || ready) && (req != '0) && !rst;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g = '0;
    if (model_load()) g[model_winner()] = 1'b1;
    return g;
  endfunction

  task automatic sample();
    @(negedge clk);
    check("m_grant", 32'(grant), 32'(model_grant()));
    check("m_valid", 32'(valid), 32'(m_valid));
    check("m_data", dout, m_data);
    check("m_sel", 32'(sel), 32'(m_sel));
  endtask

  task automatic advance();
    int  w;
    bit  ld;
    @(posedge clk);
    ld = model_load();
    w  = model_winner();
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_last  = N - 1;
    end else if (ld) begin
      m_valid = 1'b1;
      m_data  = data[w*W +: W];
      m_sel   = w;
      m_last  = w;
    end else if (ready && m_valid) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  logic [N-1:0] rot [5];

  initial begin
    rst = 1'b1; req = 4'b1111; mode = 1'b0; ready = 1'b1;
    for (int k = 0; k < N; k++) data[k*W +: W] = 32'hA000_0000 | 32'(k);
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
    @(posedge clk); #1;

    // reset held with all requests
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", dout, 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      advance();
    end
    rst = 1'b0;

    // round-robin rotation
    for (int i = 0; i < 5; i++) begin
      sample();
      check("rr_grant", 32'(grant), 32'(rot[i]));
      if (i > 0) begin
        check("rr_sel", 32'(sel), 32'(i - 1));
        check("rr_data", dout, 32'hA000_0000 | 32'(i - 1));
      end
      advance();
    end

    // skip and wrap
    req = 4'b1000;
    sample(); check("pre_wrap", 32'(grant), 32'b1000); advance();
    req = 4'b0101;
    sample(); check("wrap_g0", 32'(grant), 32'b0001); advance();
    sample(); check("wrap_g2", 32'(grant), 32'b0100); advance();
    sample(); check("wrap_g0b", 32'(grant), 32'b0001); advance();

    // backpressure while holding channel 2's word
    req = 4'b0100;
    sample(); advance();
    ready = 1'b0; req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("bp_grant", 32'(grant), 32'd0);
      check("bp_data", dout, 32'hA000_0002);
      check("bp_valid", 32'(valid), 32'd1);
      advance();
    end
    ready = 1'b1;
    sample(); check("bp_release", 32'(grant), 32'b0010); advance();

    // fixed priority, then back to round-robin
    req = 4'b1010; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("fp_grant", 32'(grant), 32'b0010);
      check("fp_data", dout, 32'hA000_0001);
      advance();
    end
    mode = 1'b0;
    sample(); check("sw_g3", 32'(grant), 32'b1000); advance();
    sample(); check("sw_g1", 32'(grant), 32'b0010); advance();

    // reset mid-operation under backpressure
    ready = 1'b0;
    rst = 1'b1;
    sample(); check("mid_rst_grant", 32'(grant), 32'd0); advance();
    rst = 1'b0;
    sample();
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_data", dout, 32'd0);
    check("mid_rst_grant2", 32'(grant), 32'b0010);
    advance();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      req   = 4'($urandom);
      mode  = 1'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) data[k*W +: W] = $urandom;
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised, registered N-to-1 data selector with round-robin or fixed-priority arbitration and a valid/ready output stage. It generalises the datapath selector to a configurable width and channel count. It adds request arbitration, a one-cycle output register and backpressure. The intended use is sharing a single memory or bus port among pipeline requesters, such as the IF and MEM stages and a write buffer.

## Interface
Parameters:
- WIDTH, 32, data width of every channel and of the output
- CHANNELS, 4, number of requesters; legal range 2..8
- SELW, $clog2(CHANNELS), width of the channel index

Ports:
- clk_i  input  1  sole clock; all state updates on its rising edge
- rst_i  input  1  reset; synchronous, active-high
- req_i  input  CHANNELS  per-channel request; bit k belongs to channel k
- data_i  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- mode_i  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- ready_i  input  1  downstream can take data_o this cycle
- grant_o  output  CHANNELS  combinational one-hot acceptance; bit k high = channel k's data is captured at this edge
- data_o  output  WIDTH  registered selected data
- sel_o  output  SELW  registered index of the channel held in data_o
- valid_o  output  1  data_o/sel_o hold an unconsumed word

## Operation
- Requester rule: channel k holds req_i[k] and its data stable until it sees grant_o[k]=1; it may drop req_i in the following cycle.
- load = (!valid_o | ready_i) & (|req_i) & !rst_i. grant_o is all-zero whenever load=0.
- Winner selection, when load=1:
  - mode_i=0: the first requesting channel found searching last_q+1, last_q+2, … modulo CHANNELS.
  - mode_i=1: the lowest-index requesting channel.
- On load: data_o <= winner's data, sel_o <= winner index, valid_o <= 1, last_q <= winner index. This applies in both modes.
- No load, ready_i & valid_o: valid_o <= 0. data_o and sel_o hold their last value.
- No load, !ready_i: all state holds; data_o, sel_o and valid_o remain stable under backpressure.
- mode_i may change in any cycle. It affects only the selection made in that same cycle, and last_q is preserved across the change.
- Internal state: last_q (SELW bits), the output register and valid_q. No other state.

## Timing
- Reset values, one edge after rst_i=1: valid_o=0, data_o=0, sel_o=0, last_q=CHANNELS-1, so channel 0 has first priority in round-robin. grant_o=0 while rst_i=1.
- Reset mid-transfer: the pending output word is discarded. A request active during reset is not granted and must be re-presented; it is not lost, because requesters hold until granted.
- Latency: 1 cycle from grant_o[k] to valid_o=1 with data_k.
- Throughput: one word per cycle while ready_i=1 and any request is pending. A word is consumed and the next is loaded in the same edge, with no bubble.
- Full/stall: valid_o=1 & ready_i=0 forces grant_o=0, and requests wait.
- Empty: valid_o=0 accepts a request regardless of ready_i.
- Wrap-around: when last_q=CHANNELS-1, the search starts at channel 0.
- Fairness: in round-robin, a continuously requesting channel is granted within CHANNELS loads.
- Single requester: granted every load cycle in both modes.

## Test plan
Bench configuration: WIDTH=32, CHANNELS=4.
- Reset: hold rst_i=1 with req_i=4'b1111 and ready_i=1 for 3 cycles -> grant_o=0, valid_o=0, data_o=0, sel_o=0. Release rst_i -> the first grant is 4'b0001.
- Round-robin rotation: mode_i=0, req_i=4'b1111, data_k=32'hA000_000k, ready_i=1 -> grants 0001, 0010, 0100, 1000, 0001 in consecutive cycles. Each word is seen on data_o with sel_o=0,1,2,3,0 one cycle later.
- Skip and wrap: last granted channel 3, req_i=4'b0101 -> grant channel 0, then channel 2, then channel 0. Channels 1 and 3 are never granted.
- Backpressure: valid_o=1 holding 32'hA000_0002 with ready_i=0 for 4 cycles and req_i=4'b0010 -> grant_o=0 and data_o is stable throughout. Raise ready_i -> channel 1 is granted in that cycle and data_o=32'hA000_0001 the next cycle.
- Fixed priority: mode_i=1, req_i=4'b1010 constant -> channel 1 is granted every cycle. Switch to mode_i=0 -> next grant is channel 3 (last_q=1), then channel 1.
- Reset mid-operation: assert rst_i for 1 cycle while valid_o=1 and ready_i=0 -> valid_o=0 and data_o=0 next cycle, last_q=3. The next grant goes to the lowest requesting channel.
